// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity serial frame transmitter.
package parity_tx_pkg;

   // Frame layout: start, DATA_BITS data bits, parity, then the stop bits.
   localparam int DATA_BITS      = 4;
   localparam int FRAME_OVERHEAD = 2;   // start + parity
   localparam int BIT_IDX_W      = $clog2(DATA_BITS);

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Parity bit for a nibble: even parity when odd_mode=0, odd parity when odd_mode=1.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd_mode);
      return (^data) ^ odd_mode;
   endfunction

endpackage

// File: rtl/parity_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap.
module parity_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic restart,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_tick = enable && (cnt_q == LAST_CNT);

   // pre_tick: the wrap will happen on the following cycle, so the parent can
   // register outputs that must line up with the last cycle of a bit.
   if (CLKS_PER_BIT == 1) begin : g_pre_single
      assign pre_tick = enable;
   end else begin : g_pre_multi
      localparam logic [CNT_W-1:0] PRE_CNT = CNT_W'(CLKS_PER_BIT - 2);
      assign pre_tick = enable && (cnt_q == PRE_CNT);
   end

   // Next count: restart wins, wrap to zero at the end of a bit, else advance.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (bit_tick) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start, 4 data bits LSB first, parity, stop bit(s).
//
// state  | meaning
// IDLE   | line high, in_ready high, waiting for in_valid
// START  | driving the start bit (low)
// DATA   | driving data bit bit_idx_q (LSB first)
// PARITY | driving the parity bit captured at accept time
// STOP   | driving stop bit stop_cnt_q (high)
module parity_serial_tx
   import parity_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_parity_mode,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 frame_done
);

   localparam logic [BIT_IDX_W-1:0] LAST_IDX  = BIT_IDX_W'(DATA_BITS - 1);
   localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 tx_serial_q, tx_serial_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;

   logic accept;
   logic bit_tick;
   logic pre_tick;

   assign in_ready   = ~busy_q;
   assign accept     = in_valid && in_ready;
   assign tx_serial  = tx_serial_q;
   assign tx_busy    = busy_q;
   assign frame_done = frame_done_q;

   parity_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (busy_q),
      .restart (accept),
      .bit_tick(bit_tick),
      .pre_tick(pre_tick)
   );

   // Next-state logic: frame sequencing, data shift and counters.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               shift_d    = in_data;
               parity_d   = calc_parity(in_data, in_parity_mode);
               bit_idx_d  = '0;
               stop_cnt_d = 1'b0;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_IDX) begin
                  state_d = PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d = IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs are derived from the upcoming state so they change on
   // the same edge as the state. frame_done is set one cycle ahead so that it
   // lands on the final cycle of the final stop bit.
   always_comb begin
      tx_serial_d  = IDLE_LEVEL;
      busy_d       = (state_d != IDLE);
      frame_done_d = 1'b0;
      unique case (state_d)
         START:   tx_serial_d = START_LEVEL;
         DATA:    tx_serial_d = shift_d[0];
         PARITY:  tx_serial_d = parity_d;
         STOP:    tx_serial_d = IDLE_LEVEL;
         default: tx_serial_d = IDLE_LEVEL;
      endcase
      if ((state_d == STOP) && (stop_cnt_d == LAST_STOP)) begin
         if (state_q != STOP || stop_cnt_q != LAST_STOP) begin
            // Just entering the last stop bit: final cycle follows only for single-cycle bits.
            frame_done_d = (CLKS_PER_BIT == 1);
         end else begin
            frame_done_d = pre_tick;
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         bit_idx_q    <= '0;
         stop_cnt_q   <= 1'b0;
         tx_serial_q  <= IDLE_LEVEL;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         bit_idx_q    <= bit_idx_d;
         stop_cnt_q   <= stop_cnt_d;
         tx_serial_q  <= tx_serial_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench: two transmitter instances (4 clk/bit + 1 stop, 1 clk/bit + 2 stop)
// compared cycle by cycle against a frame model built from the frame rules.
module tb_parity_serial_tx;

   logic       clk;
   logic       rst_n;
   logic       in_valid_a, in_valid_b;
   logic [3:0] in_data;
   logic       in_parity_mode;
   logic       in_ready_a, tx_serial_a, tx_busy_a, frame_done_a;
   logic       in_ready_b, tx_serial_b, tx_busy_b, frame_done_b;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;

   parity_serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid_a),
      .in_ready      (in_ready_a),
      .in_data       (in_data),
      .in_parity_mode(in_parity_mode),
      .tx_serial     (tx_serial_a),
      .tx_busy       (tx_busy_a),
      .frame_done    (frame_done_a)
   );

   parity_serial_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid_b),
      .in_ready      (in_ready_b),
      .in_data       (in_data),
      .in_parity_mode(in_parity_mode),
      .tx_serial     (tx_serial_b),
      .tx_busy       (tx_busy_b),
      .frame_done    (frame_done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_valid(input bit sel, input logic v);
      if (sel) in_valid_b = v;
      else     in_valid_a = v;
   endtask

   function automatic logic [3:0] obs_bits(input bit sel);
      // {tx_serial, tx_busy, in_ready, frame_done}
      return sel ? {tx_serial_b, tx_busy_b, in_ready_b, frame_done_b}
                 : {tx_serial_a, tx_busy_a, in_ready_a, frame_done_a};
   endfunction

   task automatic check_idle(input bit sel, input string tag);
      logic [3:0] o;
      o = obs_bits(sel);
      check_eq({tag, "_tx"},   o[3], 1'b1);
      check_eq({tag, "_busy"}, o[2], 1'b0);
      check_eq({tag, "_rdy"},  o[1], 1'b1);
      check_eq({tag, "_done"}, o[0], 1'b0);
   endtask

   // Sends one frame and checks every line cycle against the model.
   // post_at>0: at frame cycle post_at, drive in_valid=post_v / in_data=post_d.
   // abort_at>0: pulse reset at frame cycle abort_at and stop checking the frame.
   task automatic send_frame(input bit sel, input logic [3:0] d, input logic m,
                             input int post_at, input logic post_v, input logic [3:0] post_d,
                             input int abort_at, output int waited, output int acc_cyc);
      int         n, s, len;
      logic       exp_q[$];
      logic       acc;
      logic [3:0] o;
      n = sel ? 1 : 4;
      s = sel ? 2 : 1;
      len = (6 + s) * n;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
      exp_q.push_back(logic'(($countones(d) + int'(m)) % 2));
      for (int i = 0; i < s; i++) exp_q.push_back(1'b1);

      in_data        = d;
      in_parity_mode = m;
      set_valid(sel, 1'b1);
      waited = 0;
      acc    = 1'b0;
      while (!acc && waited < 100) begin
         acc = obs_bits(sel)[1];
         step();
         waited++;
      end
      acc_cyc = cyc_cnt;
      if (!acc) begin
         check_eq("accept_timeout", 32'd0, 32'd1);
         set_valid(sel, 1'b0);
         return;
      end
      set_valid(sel, 1'b0);
      in_data        = 4'($urandom);
      in_parity_mode = 1'($urandom);

      for (int k = 1; k <= len; k++) begin
         if (k == post_at) begin
            set_valid(sel, post_v);
            in_data = post_d;
         end
         o = obs_bits(sel);
         check_eq($sformatf("tx%0d_k%0d", sel, k),   o[3], exp_q[(k - 1) / n]);
         check_eq($sformatf("busy%0d_k%0d", sel, k), o[2], 1'b1);
         check_eq($sformatf("rdy%0d_k%0d", sel, k),  o[1], 1'b0);
         check_eq($sformatf("done%0d_k%0d", sel, k), o[0], (k == len));
         if (k == abort_at) begin
            #1 rst_n = 1'b0;
            set_valid(sel, 1'b0);
            #1;
            o = obs_bits(sel);
            check_eq("rst_async_tx",   o[3], 1'b1);
            check_eq("rst_async_busy", o[2], 1'b0);
            check_eq("rst_async_rdy",  o[1], 1'b1);
            check_eq("rst_async_done", o[0], 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            step();
            check_idle(sel, "post_rst");
            return;
         end
         step();
      end
      check_idle(sel, $sformatf("gap%0d", sel));
   endtask

   initial begin
      int w, c1, c2;
      rst_n          = 1'b0;
      in_valid_a     = 1'b0;
      in_valid_b     = 1'b0;
      in_data        = 4'h0;
      in_parity_mode = 1'b0;
      #12;
      check_idle(0, "reset_a");
      check_idle(1, "reset_b");
      #10 rst_n = 1'b1;
      step();
      check_idle(0, "rel_a");

      // Basic frame, even parity.
      send_frame(0, 4'b1011, 1'b0, 0, 1'b0, 4'h0, 0, w, c1);
      // Parity corner cases with odd mode.
      send_frame(0, 4'b0000, 1'b1, 0, 1'b0, 4'h0, 0, w, c1);
      send_frame(0, 4'b0111, 1'b1, 0, 1'b0, 4'h0, 0, w, c1);

      // in_valid held high: back-to-back frames, 29-cycle spacing.
      send_frame(0, 4'hA, 1'b0, 1, 1'b1, 4'h5, 0, w, c1);
      send_frame(0, 4'h5, 1'b0, 0, 1'b0, 4'h0, 0, w, c2);
      check_eq("b2b_wait", w, 1);
      check_eq("b2b_spacing", c2 - c1, 29);

      // in_valid raised mid-frame with 4'hF: held off until IDLE, then sent intact.
      send_frame(0, 4'h3, 1'b1, 10, 1'b1, 4'hF, 0, w, c1);
      send_frame(0, 4'hF, 1'b0, 0, 1'b0, 4'h0, 0, w, c2);
      check_eq("mid_valid_wait", w, 1);

      // Reset during data bit 2 (d2=0 so the line is low before the reset).
      send_frame(0, 4'b1011, 1'b0, 0, 1'b0, 4'h0, 14, w, c1);
      send_frame(0, 4'h6, 1'b1, 0, 1'b0, 4'h0, 0, w, c1);

      // Single-cycle bits, two stop bits.
      send_frame(1, 4'h9, 1'b0, 0, 1'b0, 4'h0, 0, w, c1);
      send_frame(1, 4'h9, 1'b0, 1, 1'b1, 4'h2, 0, w, c1);
      send_frame(1, 4'h2, 1'b1, 0, 1'b0, 4'h0, 0, w, c2);
      check_eq("b2b_spacing_b", c2 - c1, 9);

      // Randomised frames with random idle gaps on both instances.
      for (int i = 0; i < 24; i++) begin
         bit sel;
         int gap;
         sel = (i >= 14);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            check_eq("rand_idle_tx", obs_bits(sel)[3], 1'b1);
            step();
         end
         send_frame(sel, 4'($urandom), 1'($urandom), 0, 1'b0, 4'h0, 0, w, c1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
